// File: rtl/nn_pkg.sv
// Shared types and width helpers for the sequential fully-connected classifier.
package nn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    CMP,
    RESULT
  } state_e;

  localparam int unsigned DEF_N_IN      = 62;
  localparam int unsigned DEF_N_OUT     = 10;
  localparam int unsigned DEF_DW        = 8;
  localparam int unsigned DEF_WW        = 8;
  localparam int unsigned DEF_AW        = 24;
  localparam int unsigned DEF_N_SAMPLES = 750;
  localparam int unsigned DEF_BATCH     = 50;

  // Width of a counter/index covering 0..n-1, never narrower than one bit.
  function automatic int unsigned cw(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Weight ROM is neuron-major; column n_in of each neuron holds the bias.
  function automatic int unsigned rom_addr(input int unsigned n, input int unsigned k,
                                           input int unsigned n_in);
    return n * (n_in + 1) + k;
  endfunction

endpackage

// File: rtl/nn_classifier_engine_if.sv
// Sample-selector, weight-ROM and result signals of the classifier engine.
interface nn_classifier_engine_if import nn_pkg::*; #(
  parameter int unsigned N_IN      = DEF_N_IN,
  parameter int unsigned N_OUT     = DEF_N_OUT,
  parameter int unsigned DW        = DEF_DW,
  parameter int unsigned WW        = DEF_WW,
  parameter int unsigned N_SAMPLES = DEF_N_SAMPLES
);
  localparam int unsigned SW    = cw(N_SAMPLES);
  localparam int unsigned AD_W  = cw(N_OUT * (N_IN + 1));
  localparam int unsigned CLS_W = cw(N_OUT);

  logic                  start;
  logic [N_IN*DW-1:0]    in_data;
  logic [SW-1:0]         sample_idx;
  logic [AD_W-1:0]       w_addr;
  logic [WW-1:0]         w_data;
  logic [CLS_W-1:0]      class_out;
  logic                  result_valid;
  logic                  batch_done;
  logic                  done;
  logic                  busy;

  modport slave (
    input  start, in_data, w_data,
    output sample_idx, w_addr, class_out, result_valid, batch_done, done, busy
  );

  modport master (
    output start, in_data, w_data,
    input  sample_idx, w_addr, class_out, result_valid, batch_done, done, busy
  );

endinterface

// File: rtl/nn_classifier_engine_mac_unit.sv
// Single multiply-accumulate lane: unsigned input times signed weight, or signed bias,
// into a wrapping signed accumulator with optional ReLU on the output view.
module nn_mac_unit #(
  parameter int unsigned DW       = 8,
  parameter int unsigned WW       = 8,
  parameter int unsigned AW       = 24,
  parameter bit          ACT_RELU = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic                 bias_i,
  input  logic [DW-1:0]        x_i,
  input  logic signed [WW-1:0] w_i,
  output logic signed [AW-1:0] act_o
);
  localparam int unsigned PW = DW + WW + 1;

  logic signed [DW:0]    xs;
  logic signed [PW-1:0]  prod;
  logic signed [AW-1:0]  term;
  logic signed [AW-1:0]  acc_q, acc_d;

  assign xs   = $signed({1'b0, x_i});
  assign prod = PW'(xs) * PW'(w_i);
  assign term = bias_i ? AW'(w_i) : AW'(prod);

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + term;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign act_o = (ACT_RELU && acc_q[AW-1]) ? '0 : acc_q;

endmodule

// File: rtl/nn_classifier_engine.sv
// Time-multiplexed one-layer classifier: walks a batch of samples, one MAC per cycle,
// argmax over neurons, and pulses a result per sample.
module nn_classifier_engine import nn_pkg::*; #(
  parameter int unsigned N_IN      = DEF_N_IN,
  parameter int unsigned N_OUT     = DEF_N_OUT,
  parameter int unsigned DW        = DEF_DW,
  parameter int unsigned WW        = DEF_WW,
  parameter int unsigned AW        = DEF_AW,
  parameter int unsigned N_SAMPLES = DEF_N_SAMPLES,
  parameter int unsigned BATCH     = DEF_BATCH,
  parameter bit          ACT_RELU  = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  nn_classifier_engine_if.slave  bus
);
  localparam int unsigned SW    = cw(N_SAMPLES);
  localparam int unsigned AD_W  = cw(N_OUT * (N_IN + 1));
  localparam int unsigned CLS_W = cw(N_OUT);
  localparam int unsigned KW    = cw(N_IN + 1);

  state_e               state_q, state_d;
  logic [KW-1:0]        k_q, k_d;
  logic [CLS_W-1:0]     n_q, n_d;
  logic [SW-1:0]        sidx_q, sidx_d;
  logic [AD_W-1:0]      waddr_q, waddr_d;
  logic [CLS_W-1:0]     cls_q, cls_d;
  logic [CLS_W-1:0]     idx_q, idx_d;
  logic signed [AW-1:0] best_q, best_d;
  logic                 rv_q, rv_d;
  logic                 bd_q, bd_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;

  logic                 mac_clr, mac_en, mac_bias;
  logic signed [AW-1:0] act;
  logic [DW-1:0]        x_sel;
  int unsigned          kx;

  // The ROM answers one cycle late, so column k-1 is accumulated while k is addressed.
  always_comb begin
    kx = 32'(k_q);
    if (kx != 0) begin
      kx = kx - 1;
    end
    x_sel = bus.in_data[kx*DW +: DW];
  end

  nn_mac_unit #(
    .DW       (DW),
    .WW       (WW),
    .AW       (AW),
    .ACT_RELU (ACT_RELU)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (mac_clr),
    .en_i   (mac_en),
    .bias_i (mac_bias),
    .x_i    (x_sel),
    .w_i    ($signed(bus.w_data)),
    .act_o  (act)
  );

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    n_d      = n_q;
    sidx_d   = sidx_q;
    waddr_d  = waddr_q;
    cls_d    = cls_q;
    idx_d    = idx_q;
    best_d   = best_q;
    busy_d   = busy_q;
    rv_d     = 1'b0;
    bd_d     = 1'b0;
    done_d   = 1'b0;
    mac_clr  = 1'b0;
    mac_en   = 1'b0;
    mac_bias = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          busy_d  = 1'b1;
          sidx_d  = '0;
          n_d     = '0;
          k_d     = '0;
          waddr_d = '0;
        end
      end

      RUN: begin
        if (k_q == '0) begin
          mac_clr = 1'b1;
        end else begin
          mac_en = 1'b1;
        end
        if (k_q == KW'(N_IN)) begin
          state_d = DRAIN;
        end else begin
          k_d     = k_q + 1'b1;
          waddr_d = waddr_q + 1'b1;
        end
      end

      DRAIN: begin
        mac_en   = 1'b1;
        mac_bias = 1'b1;
        state_d  = CMP;
      end

      CMP: begin
        if (n_q == '0 || act > best_q) begin
          best_d = act;
          idx_d  = n_q;
        end
        if (n_q != CLS_W'(N_OUT - 1)) begin
          n_d     = n_q + 1'b1;
          k_d     = '0;
          waddr_d = AD_W'(rom_addr(32'(n_q) + 1, 0, N_IN));
          state_d = RUN;
        end else begin
          state_d = RESULT;
        end
      end

      RESULT: begin
        cls_d = idx_q;
        rv_d  = 1'b1;
        bd_d  = ((32'(sidx_q) + 1) % BATCH) == 0;
        if (sidx_q == SW'(N_SAMPLES - 1)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          sidx_d  = '0;
          state_d = IDLE;
        end else begin
          sidx_d  = sidx_q + 1'b1;
          n_d     = '0;
          k_d     = '0;
          waddr_d = '0;
          state_d = RUN;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      n_q     <= '0;
      sidx_q  <= '0;
      waddr_q <= '0;
      cls_q   <= '0;
      idx_q   <= '0;
      best_q  <= '0;
      rv_q    <= 1'b0;
      bd_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      n_q     <= n_d;
      sidx_q  <= sidx_d;
      waddr_q <= waddr_d;
      cls_q   <= cls_d;
      idx_q   <= idx_d;
      best_q  <= best_d;
      rv_q    <= rv_d;
      bd_q    <= bd_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.sample_idx   = sidx_q;
  assign bus.w_addr       = waddr_q;
  assign bus.class_out    = cls_q;
  assign bus.result_valid = rv_q;
  assign bus.batch_done   = bd_q;
  assign bus.done         = done_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_nn_classifier_engine.sv
// Randomised and directed checks of the classifier engine against a plain-arithmetic model.
module tb_nn_classifier_engine;

  localparam int N_IN = 3, N_OUT = 2, NS = 4, BT = 2;
  localparam int LAT  = N_OUT * (N_IN + 3) + 1;
  localparam int BN_IN = 62, BN_OUT = 10, BNS = 3, BBT = 50;
  localparam int BLAT  = BN_OUT * (BN_IN + 3) + 1;

  logic clk = 1'b0;
  logic rst_n;
  logic start, start_c;
  int   checks = 0;
  int   errors = 0;
  int   xgen = 0;

  int wrom_s [N_OUT*(N_IN+1)];
  int xin_s  [NS][N_IN];
  int wrom_b [BN_OUT*(BN_IN+1)];
  int xin_b  [BNS][BN_IN];

  always #5 clk = ~clk;

  nn_classifier_engine_if #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(8), .WW(8), .N_SAMPLES(NS)) ifa ();
  nn_classifier_engine_if #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(8), .WW(8), .N_SAMPLES(NS)) ifb ();
  nn_classifier_engine_if #(.N_IN(BN_IN), .N_OUT(BN_OUT), .DW(8), .WW(8), .N_SAMPLES(BNS)) ifc ();

  nn_classifier_engine #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(8), .WW(8), .AW(24),
                         .N_SAMPLES(NS), .BATCH(BT), .ACT_RELU(1'b1))
    dut_a (.clk(clk), .rst(rst_n), .bus(ifa));
  nn_classifier_engine #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(8), .WW(8), .AW(24),
                         .N_SAMPLES(NS), .BATCH(BT), .ACT_RELU(1'b0))
    dut_b (.clk(clk), .rst(rst_n), .bus(ifb));
  nn_classifier_engine #(.N_IN(BN_IN), .N_OUT(BN_OUT), .DW(8), .WW(8), .AW(24),
                         .N_SAMPLES(BNS), .BATCH(BBT), .ACT_RELU(1'b1))
    dut_c (.clk(clk), .rst(rst_n), .bus(ifc));

  assign ifa.start = start;
  assign ifb.start = start;
  assign ifc.start = start_c;

  // gen is passed only so the selectors re-evaluate after the tables are refilled.
  function automatic logic [N_IN*8-1:0] pack_s(input int s, input int gen);
    logic [N_IN*8-1:0] r;
    r = '0;
    for (int k = 0; k < N_IN; k++) r[k*8 +: 8] = 8'(xin_s[s][k] + 0 * gen);
    return r;
  endfunction

  function automatic logic [BN_IN*8-1:0] pack_b(input int s, input int gen);
    logic [BN_IN*8-1:0] r;
    r = '0;
    if (s < BNS)
      for (int k = 0; k < BN_IN; k++) r[k*8 +: 8] = 8'(xin_b[s][k] + 0 * gen);
    return r;
  endfunction

  assign ifa.in_data = pack_s(int'(ifa.sample_idx), xgen);
  assign ifb.in_data = pack_s(int'(ifb.sample_idx), xgen);
  assign ifc.in_data = pack_b(int'(ifc.sample_idx), xgen);

  always @(posedge clk) begin
    ifa.w_data <= 8'(wrom_s[ifa.w_addr]);
    ifb.w_data <= 8'(wrom_s[ifb.w_addr]);
    ifc.w_data <= (int'(ifc.w_addr) < BN_OUT*(BN_IN+1)) ? 8'(wrom_b[ifc.w_addr]) : 8'h00;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int wv(input bit big, input int a);
    return big ? wrom_b[a] : wrom_s[a];
  endfunction

  function automatic int xv(input bit big, input int s, input int k);
    return big ? xin_b[s][k] : xin_s[s][k];
  endfunction

  // Dot product plus bias per neuron, 24-bit wrap, optional ReLU, first strict maximum wins.
  function automatic int model(input bit big, input bit relu, input int s);
    int ni, no, acc, v, best, idx;
    logic [23:0] t;
    ni = big ? BN_IN : N_IN;
    no = big ? BN_OUT : N_OUT;
    best = 0;
    idx = 0;
    for (int n = 0; n < no; n++) begin
      acc = wv(big, n*(ni+1) + ni);
      for (int k = 0; k < ni; k++) acc += xv(big, s, k) * wv(big, n*(ni+1) + k);
      t = acc[23:0];
      acc = {{8{t[23]}}, t};
      v = (relu && acc < 0) ? 0 : acc;
      if (n == 0 || v > best) begin
        best = v;
        idx = n;
      end
    end
    return idx;
  endfunction

  task automatic rand_small();
    foreach (wrom_s[i]) wrom_s[i] = int'($urandom_range(0, 255)) - 128;
    foreach (xin_s[s, k]) xin_s[s][k] = int'($urandom_range(0, 255));
    xgen++;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rv"},   ifa.result_valid | ifb.result_valid, 0);
    chk({tag, "_bd"},   ifa.batch_done | ifb.batch_done, 0);
    chk({tag, "_done"}, ifa.done | ifb.done, 0);
    chk({tag, "_busy"}, ifa.busy | ifb.busy, 0);
    chk({tag, "_cls"},  ifa.class_out | ifb.class_out, 0);
    chk({tag, "_sidx"}, ifa.sample_idx | ifb.sample_idx, 0);
    chk({tag, "_addr"}, ifa.w_addr | ifb.w_addr, 0);
  endtask

  task automatic run_batch(input bit mid_start, input int rst_at,
                           output int first_a, output int first_b);
    bit exp_rv;
    int s;
    first_a = -1;
    first_b = -1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("busy_start", ifa.busy, 1);
    for (int cyc = 1; cyc <= NS*LAT + 2; cyc++) begin
      @(negedge clk);
      if (mid_start) start = (cyc == 5);
      if (rst_at != 0 && cyc == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk_zero("rst_mid");
        repeat (3) begin
          @(negedge clk);
          chk("rst_hold_busy", ifa.busy | ifb.busy, 0);
          chk("rst_hold_pulse", ifa.done | ifb.done | ifa.result_valid | ifb.result_valid, 0);
        end
        rst_n = 1'b1;
        return;
      end
      exp_rv = (cyc % LAT == 0) && (cyc / LAT <= NS);
      s = cyc / LAT - 1;
      chk("rv_a", ifa.result_valid, exp_rv);
      chk("rv_b", ifb.result_valid, exp_rv);
      chk("batch_done", ifa.batch_done, exp_rv && ((s + 1) % BT == 0));
      chk("done", ifa.done, exp_rv && (s == NS - 1));
      chk("busy", ifa.busy, cyc < NS*LAT);
      if (cyc >= LAT) begin
        if (s > NS - 1) s = NS - 1;
        chk("cls_a", ifa.class_out, model(1'b0, 1'b1, s));
        chk("cls_b", ifb.class_out, model(1'b0, 1'b0, s));
      end
      if (exp_rv) begin
        chk("sidx", ifa.sample_idx, (s == NS - 1) ? 0 : s + 1);
        if (s == 0) begin
          first_a = int'(ifa.class_out);
          first_b = int'(ifb.class_out);
        end
      end
    end
  endtask

  task automatic run_big(output int first);
    int cnt;
    first = -1;
    @(negedge clk) start_c = 1'b1;
    @(negedge clk) start_c = 1'b0;
    for (int r = 0; r < BNS; r++) begin
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (ifc.result_valid !== 1'b1 && cnt < 2*BLAT);
      chk("big_latency", cnt, BLAT);
      chk("big_cls", ifc.class_out, model(1'b1, 1'b1, r));
      if (r == 0) first = int'(ifc.class_out);
    end
    chk("big_done", ifc.done, 1);
    chk("big_bd", ifc.batch_done, 0);
    @(negedge clk);
    chk("big_busy_end", ifc.busy, 0);
  endtask

  initial begin
    int fa, fb, fc;
    rst_n = 1'b0;
    start = 1'b0;
    start_c = 1'b0;
    rand_small();
    foreach (wrom_b[i]) wrom_b[i] = 0;
    foreach (xin_b[s, k]) xin_b[s][k] = 0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    chk("reset_big", ifc.busy | ifc.result_valid | ifc.done, 0);
    rst_n = 1'b1;

    // Basic class: 6 vs 12
    rand_small();
    wrom_s = '{1, 1, 1, 0, 2, 0, 0, 10};
    xin_s[0] = '{1, 2, 3};
    xgen++;
    run_batch(1'b0, 0, fa, fb);
    chk("s1_cls_relu", fa, 1);
    chk("s1_cls_lin", fb, 1);

    // Tie 6 vs 6 keeps the lower index
    wrom_s = '{1, 1, 1, 0, 2, 0, 0, 4};
    xgen++;
    run_batch(1'b0, 0, fa, fb);
    chk("tie_relu", fa, 0);
    chk("tie_lin", fb, 0);

    // -20 vs -5: clamped tie under ReLU, -5 wins linearly
    wrom_s = '{-1, -2, -3, -6, -1, 0, 0, -4};
    xgen++;
    run_batch(1'b0, 0, fa, fb);
    chk("neg_relu", fa, 0);
    chk("neg_lin", fb, 1);

    // Control hazards
    rand_small();
    run_batch(1'b1, 0, fa, fb);
    run_batch(1'b0, 20, fa, fb);
    rand_small();
    wrom_s = '{1, 1, 1, 0, 2, 0, 0, 10};
    xin_s[0] = '{1, 2, 3};
    xgen++;
    run_batch(1'b0, 0, fa, fb);
    chk("restart_cls", fa, 1);

    repeat (4) begin
      rand_small();
      run_batch(1'b0, 0, fa, fb);
    end

    // Wide layer near full scale: 62*255*127 plus a bias only on neuron 7
    foreach (wrom_b[i]) wrom_b[i] = (i % (BN_IN + 1) == BN_IN) ? 0 : 127;
    wrom_b[7*(BN_IN+1) + BN_IN] = 127;
    foreach (xin_b[s, k]) xin_b[s][k] = 255;
    xgen++;
    run_big(fc);
    chk("ovf_cls", fc, 7);

    foreach (wrom_b[i]) wrom_b[i] = int'($urandom_range(0, 255)) - 128;
    foreach (xin_b[s, k]) xin_b[s][k] = int'($urandom_range(0, 255));
    xgen++;
    run_big(fc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nn_classifier_engine.md
Name: nn_classifier_engine

Overview:
Parametrised successor to the fixed 62-input sequential neural network top. A single time-multiplexed MAC evaluates one fully-connected layer of N_OUT neurons over N_IN inputs and selects the winning class by argmax. It walks a batch of N_SAMPLES test vectors, driving the sample index to an external input selector and the address of an external synchronous weight ROM. Widths, layer sizes, batch length and activation mode are generic.

Parameters:
N_IN, 62, inputs per sample
N_OUT, 10, neurons / classes
DW, 8, input element width, unsigned
WW, 8, weight/bias width, signed two's complement
AW, 24, accumulator width, signed; wraps on overflow
N_SAMPLES, 750, samples per run
BATCH, 50, samples per batch_done pulse
ACT_RELU, 1, 1 = ReLU before compare, 0 = linear

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  run request, sampled in IDLE only
in_data  in  N_IN*DW  current sample; element k = in_data[k*DW +: DW]; combinational function of sample_idx
sample_idx  out  clog2(N_SAMPLES)  sample being processed
w_addr  out  clog2(N_OUT*(N_IN+1))  weight ROM address
w_data  in  WW  ROM data, valid one cycle after w_addr
class_out  out  clog2(N_OUT)  winning class of last sample
result_valid  out  1  one-cycle pulse, class_out updated
batch_done  out  1  one-cycle pulse every BATCH results
done  out  1  one-cycle pulse with final result
busy  out  1  high from start acceptance to done

Behaviour:
- Reset (rst=0, async): state IDLE; sample_idx, w_addr, class_out = 0; result_valid, batch_done, done, busy = 0; accumulator, best value/index and counters cleared.
- ROM layout: neuron n, column k at n*(N_IN+1)+k; column N_IN holds the bias.
- IDLE: start=1 -> RUN next cycle, busy=1, sample_idx=0, n=0, k=0. start while busy is ignored.
- RUN: one address per cycle, k = 0..N_IN (N_IN+1 cycles). Each cycle also accumulates the previous cycle's w_data:
  - column k<N_IN: acc += zero-extended in_data[k] * w_data.
  - bias column: acc += sign-extended w_data.
  - acc is cleared at neuron start.
- DRAIN (1 cycle): accumulate the bias.
- CMP (1 cycle):
  - v = (ACT_RELU && acc<0) ? 0 : acc.
  - n==0 or v > best (strict): best=v, idx=n. Ties keep the lower index.
  - n<N_OUT-1: n++, k=0, back to RUN.
  - otherwise: go to RESULT.
- RESULT (1 cycle):
  - class_out=idx; result_valid=1.
  - batch_done=1 if (sample_idx+1) % BATCH == 0.
  - If sample_idx==N_SAMPLES-1: done=1, busy=0, sample_idx=0, state IDLE.
  - Otherwise: sample_idx++, back to RUN with n=0.
- Latency: N_OUT*(N_IN+3)+1 cycles per sample, from start acceptance (or the previous RESULT) to result_valid.
- class_out holds between results.
- No backpressure: result_valid is a pulse.
- A final sample that is a multiple of BATCH raises batch_done and done in the same cycle.
- Reset mid-run aborts immediately with no pulses; a fresh start is required.

Decomposition:
- Package nn_pkg: state enum (IDLE, RUN, DRAIN, CMP, RESULT), clog2-based width constants, ROM address helper function.
- Sub-module nn_mac_unit: accumulator with clear/enable/bias-select and ReLU output.
- Top: FSM, counters, argmax.

Test Plan:
All scenarios use N_IN=3, N_OUT=2, N_SAMPLES=4, BATCH=2 (latency 13) unless stated.
1. Basic class: in=[1,2,3]; n0 w=[1,1,1] b=0 (6), n1 w=[2,0,0] b=10 (12) -> result_valid 13 cycles after start, class_out=1, busy=1 throughout.
2. Tie: n0 = n1 = 6 -> class_out=0. Strict compare verified.
3. ReLU vs linear:
   - n0 = -20, n1 = -5, ACT_RELU=1 -> both 0 -> class_out=0.
   - Same weights, ACT_RELU=0 -> class_out=1.
4. Batch run of 4 samples:
   - result_valid at cycles 13, 26, 39, 52.
   - batch_done with results 2 and 4; done only with result 4.
   - busy falls with done; sample_idx returns to 0.
5. Control hazards:
   - start pulsed mid-run -> ignored, timing unchanged.
   - rst asserted at cycle 20 -> all outputs 0 at once, no done.
   - Restart after release gives the scenario-1 result.
6. Overflow wrap: default widths, all inputs 255, all weights 127, N_IN=62 -> acc = 2,007,870 + bias, no wrap; argmax matches the reference model.
